// File: rtl/q2_panel.sv
// Q2 front-panel conditioner: synchronizes buttons and switches, debounces the buttons
// and turns each accepted press into a single fixed-width strobe with a frozen switch value.
module q2_panel #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned PULSE_CYCLES    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        incp_btn,
    input  logic        dep_btn,
    input  logic        start_btn,
    input  logic        stop_btn,
    input  logic [11:0] sw_in,
    output logic        incp_sw,
    output logic        dep_sw,
    output logic        start_sw,
    output logic        stop_sw,
    output logic [11:0] sw
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PULSE   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    localparam logic [15:0] DB_LAST    = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYCLES - 1);

    // Button vectors are ordered {stop, start, dep, incp}, highest priority in the MSB.
    logic [3:0]  btn_meta, btn_sync;
    logic [11:0] sw_meta, sw_sync;
    logic [3:0]  stable, stable_prev;
    logic [15:0] db_cnt [4];
    logic [3:0]  press, sel, strb;
    logic [1:0]  state;
    logic [15:0] pulse_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= '0;
            btn_sync <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            btn_meta <= {stop_btn, start_btn, dep_btn, incp_btn};
            btn_sync <= btn_meta;
            sw_meta  <= sw_in;
            sw_sync  <= sw_meta;
        end
    end

    // A level is accepted only after DEBOUNCE_CYCLES uninterrupted cycles of mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable      <= '0;
            stable_prev <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            stable_prev <= stable;
            for (int i = 0; i < 4; i++) begin
                if (btn_sync[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= btn_sync[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign press = stable & ~stable_prev;

    always_comb begin
        sel = 4'b0000;
        if (press[3])      sel = 4'b1000;
        else if (press[2]) sel = 4'b0100;
        else if (press[1]) sel = 4'b0010;
        else if (press[0]) sel = 4'b0001;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            strb      <= '0;
            pulse_cnt <= '0;
            sw        <= '0;
        end else begin
            if (state == IDLE) sw <= sw_sync;
            case (state)
                IDLE: begin
                    if (|press) begin
                        strb      <= sel;
                        pulse_cnt <= PULSE_LAST;
                        state     <= PULSE;
                    end
                end
                PULSE: begin
                    if (pulse_cnt == 16'd0) begin
                        strb  <= '0;
                        state <= RELEASE;
                    end else begin
                        pulse_cnt <= pulse_cnt - 16'd1;
                    end
                end
                RELEASE: begin
                    // Wait for every button to go quiet so a held button cannot retrigger.
                    if (stable == 4'b0000) state <= IDLE;
                end
                default: begin
                    strb  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign {stop_sw, start_sw, dep_sw, incp_sw} = strb;

endmodule

// File: tb/tb_q2_panel.sv
// Directed bench for q2_panel: per-cycle expected outputs are queued as stimulus is
// driven and popped/compared one cycle at a time.
module tb_q2_panel;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        incp_btn = 1'b0, dep_btn = 1'b0, start_btn = 1'b0, stop_btn = 1'b0;
    logic [11:0] sw_in = '0;
    logic        incp_sw, dep_sw, start_sw, stop_sw;
    logic [11:0] sw;

    typedef struct packed {
        logic [3:0]  strb;
        logic [11:0] sw;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    localparam logic [3:0] NONE  = 4'b0000;
    localparam logic [3:0] INCP  = 4'b0001;
    localparam logic [3:0] DEP   = 4'b0010;
    localparam logic [3:0] START = 4'b0100;
    localparam logic [3:0] STOP  = 4'b1000;

    q2_panel #(
        .DEBOUNCE_CYCLES(4),
        .PULSE_CYCLES   (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .incp_btn (incp_btn),
        .dep_btn  (dep_btn),
        .start_btn(start_btn),
        .stop_btn (stop_btn),
        .sw_in    (sw_in),
        .incp_sw  (incp_sw),
        .dep_sw   (dep_sw),
        .start_sw (start_sw),
        .stop_sw  (stop_sw),
        .sw       (sw)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int n, input logic [3:0] strb, input logic [11:0] swv,
                        input string tag);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{strb: strb, sw: swv});
            tag_q.push_back(tag);
        end
    endtask

    task automatic check_now();
        exp_t        e;
        string       t;
        logic [3:0]  obs;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty cyc=%0d", cyc);
        end else begin
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            obs = {stop_sw, start_sw, dep_sw, incp_sw};
            assert (obs === e.strb && sw === e.sw) else begin
                errors++;
                $error("FAIL %s cyc=%0d got strb=%b sw=%h expected strb=%b sw=%h",
                       t, cyc, obs, sw, e.strb, e.sw);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_now();
        end
    endtask

    initial begin
        // Reset state
        #1;
        push(1, NONE, 12'h000, "reset_async");
        check_now();
        push(2, NONE, 12'h000, "reset_held");
        run(2);
        rst_n = 1'b1;
        push(3, NONE, 12'h000, "idle_after_reset");
        run(3);

        // Clean press of dep with sw_in=5A3
        dep_btn = 1'b1;
        sw_in   = 12'h5A3;
        push(2, NONE, 12'h000, "clean_pre_sw_old");
        push(4, NONE, 12'h5A3, "clean_debounce");
        push(2, DEP,  12'h5A3, "clean_dep_pulse");
        push(2, NONE, 12'h5A3, "clean_after");
        run(10);
        dep_btn = 1'b0;
        push(8, NONE, 12'h5A3, "clean_release");
        run(8);

        // Bouncing incp: 1,0,1,0 then held high
        incp_btn = 1'b1;
        push(10, NONE, 12'h5A3, "bounce_wait");
        run(1);
        incp_btn = 1'b0;
        run(1);
        incp_btn = 1'b1;
        run(1);
        incp_btn = 1'b0;
        run(1);
        incp_btn = 1'b1;
        run(6);
        push(2, INCP, 12'h5A3, "bounce_pulse");
        push(3, NONE, 12'h5A3, "bounce_after");
        run(5);
        incp_btn = 1'b0;
        push(8, NONE, 12'h5A3, "bounce_release");
        run(8);

        // Simultaneous start+stop: only stop fires
        start_btn = 1'b1;
        stop_btn  = 1'b1;
        push(6, NONE, 12'h5A3, "simul_wait");
        push(2, STOP, 12'h5A3, "simul_stop_pulse");
        push(4, NONE, 12'h5A3, "simul_no_start");
        run(12);
        start_btn = 1'b0;
        stop_btn  = 1'b0;
        push(8, NONE, 12'h5A3, "simul_release");
        run(8);
        start_btn = 1'b1;
        push(6, NONE, 12'h5A3, "start_wait");
        push(2, START, 12'h5A3, "start_pulse");
        push(2, NONE, 12'h5A3, "start_after");
        run(10);
        start_btn = 1'b0;
        push(8, NONE, 12'h5A3, "start_release");
        run(8);

        // sw freeze while dep is held
        dep_btn = 1'b1;
        sw_in   = 12'h0F0;
        push(2, NONE, 12'h5A3, "freeze_pre_old");
        push(4, NONE, 12'h0F0, "freeze_debounce");
        push(2, DEP,  12'h0F0, "freeze_dep_pulse");
        run(8);
        sw_in = 12'hFFF;
        push(4, NONE, 12'h0F0, "freeze_held");
        run(4);
        dep_btn = 1'b0;
        push(7, NONE, 12'h0F0, "freeze_releasing");
        push(3, NONE, 12'hFFF, "freeze_unfrozen");
        run(10);

        // Held incp: one pulse only
        incp_btn = 1'b1;
        push(6,  NONE, 12'hFFF, "held_wait");
        push(2,  INCP, 12'hFFF, "held_pulse");
        push(42, NONE, 12'hFFF, "held_no_repeat");
        run(50);
        incp_btn = 1'b0;
        push(8, NONE, 12'hFFF, "held_release");
        run(8);

        // Reset during the first stop_sw cycle
        stop_btn = 1'b1;
        push(6, NONE, 12'hFFF, "rst_wait");
        push(1, STOP, 12'hFFF, "rst_first_pulse");
        run(7);
        rst_n = 1'b0;
        #1;
        push(1, NONE, 12'h000, "rst_truncate");
        check_now();
        push(2, NONE, 12'h000, "rst_mid_held");
        run(2);
        rst_n = 1'b1;
        push(2, NONE, 12'h000, "rst_relaunch_sw_old");
        push(4, NONE, 12'hFFF, "rst_relaunch_wait");
        push(2, STOP, 12'hFFF, "rst_relaunch_pulse");
        push(2, NONE, 12'hFFF, "rst_relaunch_after");
        run(10);
        stop_btn = 1'b0;
        push(8, NONE, 12'hFFF, "rst_release");
        run(8);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_leftover got %0d entries expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
